imm_encoder: RTL and testbench

- Inverse of the core's immediate extractor: takes a 32-bit immediate, an immediate-type code and a base instruction word, and scatters the immediate bits into the RISC-V I/S/B/J/U field positions.
- Used by the self-test/instruction-patch path to build instruction words.
- Two-stage valid/ready pipeline with per-beat range/alignment/type checking and a saturating error counter.

---
 rtl/imm_encoder.sv | 211 +++++++++++++++++++++
 tb/tb_imm_encoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//
// Builds RISC-V instruction words by placing a 32-bit immediate into the
// I/S/B/J/U immediate fields of a base instruction word. This is the inverse
// of the core's immediate extractor, and the self-test/instruction-patch path
// uses it.
//
// Each beat is checked for three errors:
//   range_err - the immediate does not fit the selected format
//   align_err - a B/J immediate has bit 0 set
//   type_err  - the immediate-type code is illegal
// A saturating counter records how many delivered beats had an error.
//
// Pipeline: two stages with valid/ready flow control.
//   stage 1 - registers the input beat; the encoding and the flags are
//             computed combinationally from these registers
//   stage 2 - output register holding instr_out and the flags
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     input beat offered
//   in_ready     input beat accepted when in_valid && in_ready
//   imm_type     000 I, 001 S, 010 B, 011 J, 100 U, others illegal
//   imm          immediate, two's complement
//   base_instr   source of all non-immediate instruction bits
//   out_valid    output beat present
//   out_ready    downstream accepts when out_valid && out_ready
//   instr_out    encoded instruction
//   range_err    immediate not representable in the format
//   align_err    B/J immediate with bit 0 set
//   type_err     illegal imm_type
//   cnt_clr      synchronous clear of err_count
//   err_count    saturating count of delivered beats that had an error
// -----------------------------------------------------------------------------
module imm_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       imm_type,
    input  logic [31:0]      imm,
    input  logic [31:0]      base_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr_out,
    output logic             range_err,
    output logic             align_err,
    output logic             type_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0] TYPE_I = 3'b000;
    localparam logic [2:0] TYPE_S = 3'b001;
    localparam logic [2:0] TYPE_B = 3'b010;
    localparam logic [2:0] TYPE_J = 3'b011;
    localparam logic [2:0] TYPE_U = 3'b100;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage 1: registered input beat.
    logic        r_s1_valid;
    logic [2:0]  r_s1_type;
    logic [31:0] r_s1_imm;
    logic [31:0] r_s1_base;

    // Stage 2: output register.
    logic        r_s2_valid;
    logic [31:0] r_instr;
    logic        r_range_err;
    logic        r_align_err;
    logic        r_type_err;

    logic [CNT_W-1:0] r_err_count;

    // Flow control.
    logic w_s2_load;
    logic w_s1_load;
    logic w_out_fire;

    // Stage-1 encoding results.
    logic [31:0] w_instr;
    logic        w_range_err;
    logic        w_align_err;
    logic        w_type_err;

    // Sign-extension checks. The immediate fits when every bit above the
    // top bit of the field equals that top bit.
    logic w_fits_12;
    logic w_fits_13;
    logic w_fits_21;
    logic w_low12_zero;

    // A stage loads when it is empty or its contents leave in the same cycle.
    // The ready chain is combinational, so a full pipeline that is draining
    // still accepts one beat per cycle.
    assign w_s2_load  = !r_s2_valid || out_ready;
    assign w_s1_load  = !r_s1_valid || w_s2_load;
    assign w_out_fire = r_s2_valid && out_ready;

    assign in_ready = w_s1_load;

    assign w_fits_12    = (&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]);
    assign w_fits_13    = (&r_s1_imm[31:12]) || !(|r_s1_imm[31:12]);
    assign w_fits_21    = (&r_s1_imm[31:20]) || !(|r_s1_imm[31:20]);
    assign w_low12_zero = !(|r_s1_imm[11:0]);

    // Scatter the immediate into the field positions of the selected format.
    // Out-of-range immediates still encode their truncated low bits. For B
    // and J, bit 0 is not encoded.
    always_comb begin
        w_instr     = r_s1_base;
        w_range_err = 1'b0;
        w_align_err = 1'b0;
        w_type_err  = 1'b0;
        case (r_s1_type)
            TYPE_I: begin
                w_instr[31:20] = r_s1_imm[11:0];
                w_range_err    = !w_fits_12;
            end
            TYPE_S: begin
                w_instr[31:25] = r_s1_imm[11:5];
                w_instr[11:7]  = r_s1_imm[4:0];
                w_range_err    = !w_fits_12;
            end
            TYPE_B: begin
                w_instr[31]    = r_s1_imm[12];
                w_instr[30:25] = r_s1_imm[10:5];
                w_instr[11:8]  = r_s1_imm[4:1];
                w_instr[7]     = r_s1_imm[11];
                w_range_err    = !w_fits_13;
                w_align_err    = r_s1_imm[0];
            end
            TYPE_J: begin
                w_instr[31]    = r_s1_imm[20];
                w_instr[30:21] = r_s1_imm[10:1];
                w_instr[20]    = r_s1_imm[11];
                w_instr[19:12] = r_s1_imm[19:12];
                w_range_err    = !w_fits_21;
                w_align_err    = r_s1_imm[0];
            end
            TYPE_U: begin
                w_instr[31:12] = r_s1_imm[31:12];
                w_range_err    = !w_low12_zero;
            end
            default: begin
                w_type_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_type  <= 3'b000;
            r_s1_imm   <= 32'h0;
            r_s1_base  <= 32'h0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_type <= imm_type;
                r_s1_imm  <= imm;
                r_s1_base <= base_instr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_instr     <= 32'h0;
            r_range_err <= 1'b0;
            r_align_err <= 1'b0;
            r_type_err  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_instr     <= w_instr;
                r_range_err <= w_range_err;
                r_align_err <= w_align_err;
                r_type_err  <= w_type_err;
            end
        end
    end

    // The counter advances only when a beat is delivered downstream, so a
    // beat that stalls in stage 2 is counted once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (cnt_clr) begin
            r_err_count <= '0;
        end else if (w_out_fire && (r_range_err || r_align_err || r_type_err)
                     && (r_err_count != CNT_MAX)) begin
            r_err_count <= r_err_count + CNT_ONE;
        end
    end

    assign out_valid = r_s2_valid;
    assign instr_out = r_instr;
    assign range_err = r_range_err;
    assign align_err = r_align_err;
    assign type_err  = r_type_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       imm_type;
    logic [31:0]      imm;
    logic [31:0]      base_instr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instr_out;
    logic             range_err;
    logic             align_err;
    logic             type_err;
    logic             cnt_clr;
    logic [CNT_W-1:0] err_count;

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .imm_type(imm_type), .imm(imm), .base_instr(base_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr_out(instr_out), .range_err(range_err),
        .align_err(align_err), .type_err(type_err),
        .cnt_clr(cnt_clr), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        rng;
        logic        aln;
        logic        typ;
    } beat_t;

    beat_t       sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          m_cnt    = 0;
    bit          last_acc;
    bit          hold_pend = 0;
    logic [34:0] hold_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: field placement by shift-and-mask arithmetic, range by
    // signed interval comparison.
    function automatic beat_t model(input logic [2:0] t, input logic [31:0] v,
                                    input logic [31:0] b);
        beat_t r;
        int    s;
        s     = $signed(v);
        r.rng = 1'b0;
        r.aln = 1'b0;
        r.typ = 1'b0;
        case (t)
            3'd0: begin
                r.instr = (b & 32'h000F_FFFF) | ((v & 32'hFFF) << 20);
                r.rng   = !(s >= -2048 && s <= 2047);
            end
            3'd1: begin
                r.instr = (b & ~32'hFE00_0F80) | (((v >> 5) & 32'h7F) << 25)
                        | ((v & 32'h1F) << 7);
                r.rng   = !(s >= -2048 && s <= 2047);
            end
            3'd2: begin
                r.instr = (b & ~32'hFE00_0F80) | (((v >> 12) & 32'h1) << 31)
                        | (((v >> 5) & 32'h3F) << 25) | (((v >> 1) & 32'hF) << 8)
                        | (((v >> 11) & 32'h1) << 7);
                r.rng   = !(s >= -4096 && s <= 4095);
                r.aln   = (v % 2) == 1;
            end
            3'd3: begin
                r.instr = (b & 32'h0000_0FFF) | (((v >> 20) & 32'h1) << 31)
                        | (((v >> 1) & 32'h3FF) << 21) | (((v >> 11) & 32'h1) << 20)
                        | (((v >> 12) & 32'hFF) << 12);
                r.rng   = !(s >= -1048576 && s <= 1048575);
                r.aln   = (v % 2) == 1;
            end
            3'd4: begin
                r.instr = (b & 32'h0000_0FFF) | (v & 32'hFFFF_F000);
                r.rng   = (v % 4096) != 0;
            end
            default: begin
                r.instr = b;
                r.typ   = 1'b1;
            end
        endcase
        return r;
    endfunction

    // One clock cycle. Entered at a falling edge with inputs already driven;
    // returns at the next falling edge.
    task automatic step();
        bit    oh;
        beat_t e;
        #1;
        last_acc = in_valid && in_ready;
        oh       = out_valid && out_ready;
        if (hold_pend) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_data", instr_out, hold_val[34:3]);
            chk("hold_flags", {29'b0, range_err, align_err, type_err}, {29'b0, hold_val[2:0]});
        end
        if (oh) begin
            chk("sb_nonempty", {31'b0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("instr_out", instr_out, e.instr);
                chk("range_err", {31'b0, range_err}, {31'b0, e.rng});
                chk("align_err", {31'b0, align_err}, {31'b0, e.aln});
                chk("type_err", {31'b0, type_err}, {31'b0, e.typ});
                if (!cnt_clr && (e.rng || e.aln || e.typ) && m_cnt < (1 << CNT_W) - 1)
                    m_cnt++;
            end
        end
        if (cnt_clr) m_cnt = 0;
        if (last_acc) sb.push_back(model(imm_type, imm, base_instr));
        hold_pend = out_valid && !out_ready;
        hold_val  = {instr_out, range_err, align_err, type_err};
        @(posedge clk);
        #1;
        chk("err_count", {{(32-CNT_W){1'b0}}, err_count}, m_cnt);
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] t, input logic [31:0] v, input logic [31:0] b);
        bit done;
        done       = 0;
        in_valid   = 1'b1;
        imm_type   = t;
        imm        = v;
        base_instr = b;
        for (int k = 0; k < 20 && !done; k++) begin
            step();
            done = last_acc;
        end
        chk("send_accept", {31'b0, done}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() > 0; k++) step();
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    idx;
        beat_t bp[3];

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        cnt_clr    = 1'b0;
        imm_type   = 3'd0;
        imm        = 32'h0;
        base_instr = 32'h0;
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_flags", {29'b0, range_err, align_err, type_err}, 32'd0);
        chk("rst_err_count", {{(32-CNT_W){1'b0}}, err_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // I-type with latency check
        in_valid = 1'b1; imm_type = 3'd0; imm = 32'hFFFF_FFFF; base_instr = 32'h0000_0013;
        step();
        chk("i_accept", {31'b0, last_acc}, 32'd1);
        chk("lat_edge_n", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b0;
        step();
        chk("lat_edge_n1", {31'b0, out_valid}, 32'd1);
        chk("i_instr", instr_out, 32'hFFF0_0013);
        chk("i_flags", {29'b0, range_err, align_err, type_err}, 32'd0);
        drain();

        // B, J, U directed
        send(3'd2, 32'h0000_0FFE, 32'h0000_0063);
        drain();
        send(3'd2, 32'h0000_0003, 32'h0000_0063);
        drain();
        chk("b_align_count", {{(32-CNT_W){1'b0}}, err_count}, 32'd1);
        send(3'd3, 32'h0010_0000, 32'h0000_006F);
        drain();
        chk("j_range_count", {{(32-CNT_W){1'b0}}, err_count}, 32'd2);
        send(3'd4, 32'h1234_5000, 32'h0000_0037);
        send(3'd4, 32'h1234_5001, 32'h0000_0037);
        drain();

        // Illegal type and counter saturation
        send(3'd5, 32'h0000_0000, 32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) send(3'(5 + (k % 3)), 32'h1, 32'hDEAD_BEEF);
        drain();
        chk("sat_count", {{(32-CNT_W){1'b0}}, err_count}, 32'd3);

        // Clear takes priority over a simultaneous error handshake
        out_ready = 1'b0;
        send(3'd6, 32'h0, 32'h1111_1111);
        for (int k = 0; k < 10 && !out_valid; k++) step();
        chk("clr_setup_valid", {31'b0, out_valid}, 32'd1);
        cnt_clr   = 1'b1;
        out_ready = 1'b1;
        step();
        chk("clr_priority", {{(32-CNT_W){1'b0}}, err_count}, 32'd0);
        cnt_clr = 1'b0;
        drain();

        // Backpressure: three beats offered, two fit
        bp[0] = '{instr: 32'h0000_0013, rng: 0, aln: 0, typ: 0};
        bp[1] = '{instr: 32'h0000_0023, rng: 0, aln: 0, typ: 0};
        bp[2] = '{instr: 32'h0000_0037, rng: 0, aln: 0, typ: 0};
        out_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; imm_type = 3'(idx); imm = 32'h10 + idx; base_instr = bp[idx].instr;
            step();
            if (last_acc) idx++;
        end
        chk("bp_accepted", idx, 2);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 10 && idx < 3; k++) begin
            imm_type = 3'(idx); imm = 32'h10 + idx; base_instr = bp[idx].instr;
            step();
            if (last_acc) idx++;
        end
        chk("bp_third", idx, 3);
        in_valid = 1'b0;
        drain();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            cnt_clr   = ($urandom % 40) == 0;
            imm_type  = 3'($urandom_range(0, 7));
            base_instr = $urandom;
            case ($urandom % 4)
                0: imm = $urandom;
                1: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
                2: imm = 32'($signed($urandom_range(0, 4194303)) - 2097152);
                default: imm = {$urandom_range(0, 1048575), 12'($urandom % 2)};
            endcase
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        drain();

        // Reset with two beats buffered and a nonzero count
        send(3'd7, 32'h0, 32'h0);
        drain();
        out_ready = 1'b0;
        send(3'd0, 32'h5, 32'h0000_0013);
        send(3'd1, 32'h7, 32'h0000_0023);
        chk("pre_rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_count", {{(32-CNT_W){1'b0}}, err_count}, 32'd0);
        sb.delete();
        m_cnt     = 0;
        hold_pend = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        send(3'd0, 32'h0000_07FF, 32'h0000_0093);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
